// File: rtl/j_raster_scanner_pkg.sv
// Shared constants, types and FSM state encoding for the raster scanner.
package j_img_pkg;

  localparam int DIM_W  = 13;
  localparam int ADDR_W = 2 * DIM_W;

  typedef logic [DIM_W-1:0]  dim_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/j_raster_scanner_if.sv
// Pixel beat stream: one (row, col, address) beat per pixel with frame/line markers.
interface j_raster_scanner_if #(
  parameter int DIM_W  = j_img_pkg::DIM_W,
  parameter int ADDR_W = j_img_pkg::ADDR_W
);

  logic              out_valid;
  logic              out_ready;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  col;
  logic [ADDR_W-1:0] pix_addr;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    output out_valid, row, col, pix_addr, sof, eol, eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, row, col, pix_addr, sof, eol, eof,
    output out_ready
  );

endinterface

// File: rtl/j_raster_scanner_col_counter.sv
// Enabled column counter: counts 0..rollover_val-1 and wraps, flagging the last column.
module j_col_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count,
  output logic         rollover_flag
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;

  // Column register: wrap to zero on the last column, otherwise increment.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= rollover_flag ? '0 : cnt_q + ONE;
    end
  end

  assign count         = cnt_q;
  assign rollover_flag = (cnt_q == rollover_val - ONE);

endmodule

// File: rtl/j_raster_scanner.sv
// Raster-scan pixel coordinate generator. Latches frame dimensions on start and
// emits row-major beats; pix_addr is a running counter, so no multiplier.
//
// state | meaning
// IDLE  | waiting for start; counters held at zero
// SCAN  | presenting beats, advancing on each accepted transfer
// DONE  | one-cycle done pulse, then back to IDLE
module j_raster_scanner #(
  parameter int DIM_W  = j_img_pkg::DIM_W,
  parameter int ADDR_W = j_img_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic [DIM_W-1:0]    img_width,
  input  logic [DIM_W-1:0]    img_height,
  j_raster_scanner_if.master  beat,
  output logic                busy,
  output logic                done,
  output logic                dim_err
);

  import j_img_pkg::*;

  localparam logic [DIM_W-1:0]  DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  width_q, height_q, row_q, col;
  logic [ADDR_W-1:0] addr_q;
  logic              dim_err_q;
  logic              col_last, row_last, frame_last;
  logic              xfer, start_ok, start_bad, col_clear;
  logic              scan_valid;

  assign start_ok   = (state_q == IDLE) && start && (img_width != '0) && (img_height != '0);
  assign start_bad  = (state_q == IDLE) && start && ((img_width == '0) || (img_height == '0));
  assign xfer       = (state_q == SCAN) && beat.out_ready;
  assign row_last   = (row_q == height_q - DIM_ONE);
  assign frame_last = col_last && row_last;
  assign col_clear  = clear || (state_q != SCAN);

  j_col_counter #(.W(DIM_W)) u_col (
    .clk           (clk),
    .clear         (col_clear),
    .en            (xfer),
    .rollover_val  (width_q),
    .count         (col),
    .rollover_flag (col_last)
  );

  // State register; clear overrides everything, including a same-cycle start.
  always_ff @(posedge clk) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Frame dimensions are captured only when a valid start is accepted.
  always_ff @(posedge clk) begin
    if (clear) begin
      width_q  <= '0;
      height_q <= '0;
    end else if (start_ok) begin
      width_q  <= img_width;
      height_q <= img_height;
    end
  end

  // Row index and running linear address advance on accepted transfers.
  always_ff @(posedge clk) begin
    if (clear || (state_q != SCAN)) begin
      row_q  <= '0;
      addr_q <= '0;
    end else if (xfer) begin
      if (frame_last) begin
        row_q  <= '0;
        addr_q <= '0;
      end else begin
        addr_q <= addr_q + ADDR_ONE;
        if (col_last) row_q <= row_q + DIM_ONE;
      end
    end
  end

  // Zero-dimension start request produces a single-cycle error pulse.
  always_ff @(posedge clk) begin
    if (clear) dim_err_q <= 1'b0;
    else       dim_err_q <= start_bad;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    scan_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = SCAN;
      end
      SCAN: begin
        scan_valid = 1'b1;
        busy       = 1'b1;
        if (xfer && frame_last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat.out_valid = scan_valid;
  assign beat.row       = row_q;
  assign beat.col       = col;
  assign beat.pix_addr  = addr_q;
  assign beat.sof       = scan_valid && (row_q == '0) && (col == '0);
  assign beat.eol       = scan_valid && col_last;
  assign beat.eof       = scan_valid && frame_last;
  assign dim_err        = dim_err_q;

endmodule

// File: tb/tb_j_raster_scanner.sv
// Directed bench for j_raster_scanner: full frames, stalls, dimension errors,
// clear mid-frame and a maximum-width frame with an ignored start re-pulse.
module tb_j_raster_scanner;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [12:0] img_width;
  logic [12:0] img_height;
  logic        busy, done, dim_err;

  int checks = 0;
  int errors = 0;

  j_raster_scanner_if rif ();

  j_raster_scanner dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .beat       (rif),
    .busy       (busy),
    .done       (done),
    .dim_err    (dim_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int w, input int h);
    img_width  = 13'(w);
    img_height = 13'(h);
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; img_width = '0; img_height = '0; rif.out_ready = 1'b0;
    step(); step();
    clear = 1'b0;
    checks++;
    if ({rif.out_valid, rif.sof, rif.eol, rif.eof, busy, done, dim_err} !== 7'b0 ||
        rif.row !== 13'd0 || rif.col !== 13'd0 || rif.pix_addr !== 26'd0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b done=%b dim_err=%b row=%0d col=%0d addr=%0d, want all 0",
               rif.out_valid, busy, done, dim_err, rif.row, rif.col, rif.pix_addr);
    end
  endtask

  // Full frame with out_ready held high; every beat checked against row-major order.
  task automatic test_frame(input string name, input int w, input int h);
    int n;
    int total;
    total = w * h;
    rif.out_ready = 1'b1;
    kick(w, h);
    for (n = 0; n < total; n++) begin
      checks++;
      if (rif.out_valid !== 1'b1 || rif.row !== 13'(n / w) || rif.col !== 13'(n % w) ||
          rif.pix_addr !== 26'(n) || rif.sof !== (n == 0) || rif.eol !== ((n % w) == w - 1) ||
          rif.eof !== (n == total - 1) || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s beat %0d: v=%b row=%0d col=%0d addr=%0d sof=%b eol=%b eof=%b done=%b, want row=%0d col=%0d addr=%0d sof=%b eol=%b eof=%b",
                 name, n, rif.out_valid, rif.row, rif.col, rif.pix_addr, rif.sof, rif.eol, rif.eof, done,
                 n / w, n % w, n, n == 0, (n % w) == w - 1, n == total - 1);
      end
      step();
    end
    checks++;
    if (rif.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: valid=%b done=%b busy=%b, want 0 1 1", name, rif.out_valid, done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_stall();
    bit [3:0] pat;
    int n, c;
    pat = 4'b1001;   // bit index c%4: ready = 1,0,0,1
    n = 0;
    c = 0;
    kick(5, 2);
    while (n < 10 && c < 100) begin
      rif.out_ready = pat[c % 4];
      checks++;
      if (rif.out_valid !== 1'b1 || rif.row !== 13'(n / 5) || rif.col !== 13'(n % 5) ||
          rif.pix_addr !== 26'(n) || rif.eol !== ((n % 5) == 4) || rif.eof !== (n == 9)) begin
        errors++;
        $display("FAIL stall cycle %0d: v=%b row=%0d col=%0d addr=%0d eol=%b eof=%b, want beat %0d",
                 c, rif.out_valid, rif.row, rif.col, rif.pix_addr, rif.eol, rif.eof, n);
      end
      if (rif.out_ready) n++;
      step();
      c++;
    end
    rif.out_ready = 1'b1;
    checks++;
    if (n != 10 || c != 20 || done !== 1'b1) begin
      errors++;
      $display("FAIL stall_end: beats=%0d cycles=%0d done=%b, want 10 20 1", n, c, done);
    end
    step();
  endtask

  task automatic test_dim_err();
    kick(0, 7);
    checks++;
    if (dim_err !== 1'b1 || rif.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dim_err_pulse: dim_err=%b valid=%b busy=%b, want 1 0 0", dim_err, rif.out_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dim_err !== 1'b0 || rif.out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL dim_err_after %0d: dim_err=%b valid=%b busy=%b, want 0 0 0", i, dim_err, rif.out_valid, busy);
      end
    end
    kick(6, 0);
    checks++;
    if (dim_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dim_err_h0: dim_err=%b busy=%b, want 1 0", dim_err, busy);
    end
    step();
  endtask

  task automatic test_clear_mid();
    rif.out_ready = 1'b1;
    kick(10, 10);
    for (int i = 0; i < 37; i++) step();
    rif.out_ready = 1'b0;
    step(); step();
    checks++;
    if (rif.out_valid !== 1'b1 || rif.row !== 13'd3 || rif.col !== 13'd7 || rif.pix_addr !== 26'd37) begin
      errors++;
      $display("FAIL clear_hold: v=%b row=%0d col=%0d addr=%0d, want 1 3 7 37",
               rif.out_valid, rif.row, rif.col, rif.pix_addr);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (rif.out_valid !== 1'b0 || rif.row !== 13'd0 || rif.col !== 13'd0 || rif.pix_addr !== 26'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid: v=%b row=%0d col=%0d addr=%0d busy=%b done=%b, want all 0",
               rif.out_valid, rif.row, rif.col, rif.pix_addr, busy, done);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_done: done=%b busy=%b, want 0 0", done, busy);
    end
    // clear and start together: clear wins
    img_width = 13'd3; img_height = 13'd3; clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || rif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_start: busy=%b valid=%b, want 0 0", busy, rif.out_valid);
    end
    test_frame("restart2x2", 2, 2);
  endtask

  task automatic test_big();
    int n;
    int total;
    total = 8191 * 2;
    rif.out_ready = 1'b1;
    kick(8191, 2);
    for (n = 0; n < total; n++) begin
      if (n == 100) begin img_width = 13'd4; img_height = 13'd4; start = 1'b1; end
      if (n == 101) start = 1'b0;
      checks++;
      if (rif.out_valid !== 1'b1 || rif.pix_addr !== 26'(n) || rif.row !== 13'(n / 8191) ||
          rif.col !== 13'(n % 8191) || rif.eof !== (n == total - 1)) begin
        errors++;
        $display("FAIL big beat %0d: v=%b row=%0d col=%0d addr=%0d eof=%b, want row=%0d col=%0d addr=%0d",
                 n, rif.out_valid, rif.row, rif.col, rif.pix_addr, rif.eof, n / 8191, n % 8191, n);
        if (errors > 20) break;
      end
      if (n == total - 1) begin
        checks++;
        if (rif.row !== 13'd1 || rif.col !== 13'd8190 || rif.pix_addr !== 26'd16381 ||
            rif.eof !== 1'b1 || rif.eol !== 1'b1) begin
          errors++;
          $display("FAIL big_last: row=%0d col=%0d addr=%0d eof=%b eol=%b, want 1 8190 16381 1 1",
                   rif.row, rif.col, rif.pix_addr, rif.eof, rif.eol);
        end
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || rif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL big_done: done=%b valid=%b, want 1 0", done, rif.out_valid);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_frame("frame4x3", 4, 3);
    test_stall();
    test_dim_err();
    test_frame("frame1x1", 1, 1);
    test_frame("width1", 1, 3);
    test_frame("height1", 3, 1);
    test_clear_mid();
    test_big();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/j_raster_scanner.md
Name: j_raster_scanner

Overview:
- Raster-scan pixel coordinate generator for the image-indexing path.
- Latches image width and height on a start pulse. Emits one (row, col, linear address) beat per pixel over a valid/ready handshake.
- Beats are produced in row-major order. Frame/line markers accompany each beat.
- Sits directly upstream of the image-buffer read stage. Its end-of-line beat acceptance is the event that advances row indexing.

Parameters:
- DIM_W, 13, width of image dimensions and row/col coordinates
- ADDR_W, 26, width of linear pixel address (2*DIM_W)

Ports:
- clk  in  1  system clock
- clear  in  1  synchronous, active-high reset; returns block to IDLE on the next rising edge
- start  in  1  one-cycle request to begin a frame; ignored unless IDLE
- img_width  in  DIM_W  pixels per row; sampled when start accepted
- img_height  in  DIM_W  rows per frame; sampled when start accepted
- out_ready  in  1  downstream accepts current beat
- out_valid  out  1  beat present
- row  out  DIM_W  current row index
- col  out  DIM_W  current column index
- pix_addr  out  ADDR_W  row*width + col
- sof  out  1  beat is (0,0)
- eol  out  1  beat is last column of row
- eof  out  1  beat is last pixel of frame
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at frame end
- dim_err  out  1  one-cycle pulse when start seen with a zero dimension

Behaviour:
- Reset values: all outputs 0, state IDLE, latched dimensions 0.
- States: IDLE, SCAN, DONE.
- IDLE, start=1, both dims nonzero:
  - Latch width and height.
  - Go to SCAN; out_valid=1 on the following cycle with row=0, col=0, pix_addr=0, sof=1.
  - Latency from start edge to first valid beat: 1 cycle.
- IDLE, start=1, either dim zero: dim_err=1 for one cycle; remain IDLE; dims not latched.
- SCAN handshake:
  - A beat transfers on a rising edge with out_valid && out_ready.
  - While out_valid && !out_ready, row/col/pix_addr/flags hold stable.
  - out_valid stays 1 throughout SCAN; no bubbles between beats.
- Advance on transfer:
  - col < width-1: col+1, pix_addr+1.
  - col == width-1 and row < height-1: col=0, row+1, pix_addr+1. The address is contiguous row-major, so no multiplier is used; pix_addr is a running counter.
  - col == width-1 and row == height-1: this beat has eof=1. On transfer go to DONE and deassert out_valid.
- Flags:
  - sof = (row==0 && col==0).
  - eol = (col==width-1).
  - eof = eol && row==height-1.
  - All flags qualified by out_valid.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in SCAN and DONE.
- width=1: every beat has eol=1.
- height=1: eof coincides with the first eol.
- 1x1 frame: single beat with sof=eol=eof=1.
- start while busy: ignored; latched dims unchanged mid-frame.
- clear mid-frame, including while a beat is stalled: next cycle out_valid=0, state IDLE, counters 0, no done pulse.
- clear and start in the same cycle: clear wins.
- Max dims 8191x8191: pix_addr reaches 67,092,480, which fits in 26 bits. No counter wraps within a legal frame.

Decomposition:
- Package j_img_pkg:
  - DIM_W, ADDR_W constants
  - dim_t/addr_t typedefs
  - state enum {IDLE, SCAN, DONE}
- Sub-module: j_col_counter. Enabled column counter with clear, rollover_val=width and rollover_flag at width-1.
- Row advance and state FSM stay in the top.

Test Plan:
- clear; start with width=4, height=3, out_ready=1 -> 12 consecutive beats with pix_addr 0..11. sof on beat 0; eol on cols 3; eof only on beat 11. done pulses 1 cycle after beat 11; busy falls next cycle.
- width=5, height=2, out_ready toggling 1,0,0,1 -> outputs hold during the low cycles; all 10 beats appear once, in order; no duplicates.
- start with width=0, height=7 -> dim_err one pulse; out_valid never asserted; busy stays 0.
- width=1, height=1 -> single beat row=0, col=0, sof=eol=eof=1; done one cycle after transfer.
- Mid-frame (width=10, height=10, after 37 beats) assert clear with out_ready=0 -> next cycle out_valid=0, row=col=0, busy=0, no done. A subsequent start restarts at (0,0).
- width=8191, height=2, out_ready=1, start re-pulsed mid-frame -> start ignored. Last beat row=1, col=8190, pix_addr=16381, eof=1.
